rst_seq_ctrl: RTL and testbench



---
 rtl/rst_seq_ctrl_if.sv | 19 +
 rtl/rst_seq_ctrl.sv | 129 ++++++++++++
 tb/tb_rst_seq_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_ctrl_if.sv
// Request/status bundle between a software-reset requester and rst_seq_ctrl.
interface rst_seq_ctrl_if;
   logic        req_i;
   logic [15:0] req_len_i;
   logic        rst_no;
   logic        busy_o;
   logic        ack_o;
   logic [7:0]  sw_rst_cnt_o;

   modport master (
      output req_i, req_len_i,
      input  rst_no, busy_o, ack_o, sw_rst_cnt_o
   );

   modport slave (
      input  req_i, req_len_i,
      output rst_no, busy_o, ack_o, sw_rst_cnt_o
   );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: synchronized release, programmable hold, software reset handshake.
// Define RST_SEQ_CTRL_STATS_EN to build the saturating completed-software-reset counter.
//
// state  | meaning
// ASSERT | raw reset active or just released; chain and counters cleared
// SYNC   | shifting a 1 through the release synchronizer
// HOLD   | output reset held low while the counter runs down
// RUN    | output reset released; software requests accepted here
// SWRST  | software reset in progress, counting down the latched length
module rst_seq_ctrl #(
   parameter int unsigned SyncStages = 2,
   parameter int unsigned HoldCycles = 100
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   rst_seq_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_ASSERT,
      ST_SYNC,
      ST_HOLD,
      ST_RUN,
      ST_SWRST
   } state_e;

   localparam logic [15:0] HoldLoad = 16'(HoldCycles - 1);

   state_e                  state_q, state_d;
   logic [SyncStages-1:0]   sync_q, sync_d;
   logic [15:0]             cnt_q, cnt_d;
   logic                    sw_q, sw_d;
   logic                    rst_no_q, rst_no_d;
   logic                    ack_q, ack_d;

   always_comb begin
      state_d = state_q;
      sync_d  = sync_q;
      cnt_d   = cnt_q;
      sw_d    = sw_q;
      ack_d   = 1'b0;

      unique case (state_q)
         ST_ASSERT, ST_SYNC: begin
            // Leave SYNC on the edge that sets the last stage, so HOLD starts immediately
            sync_d = {sync_q[SyncStages-2:0], 1'b1};
            if (sync_d[SyncStages-1]) begin
               state_d = ST_HOLD;
               cnt_d   = HoldLoad;
            end else begin
               state_d = ST_SYNC;
            end
         end
         ST_HOLD: begin
            if (cnt_q == 16'd0) begin
               state_d = ST_RUN;
               ack_d   = sw_q;
               sw_d    = 1'b0;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_RUN: begin
            if (bus.req_i) begin
               state_d = ST_SWRST;
               sw_d    = 1'b1;
               cnt_d   = (bus.req_len_i == 16'd0) ? 16'd0 : bus.req_len_i - 16'd1;
            end
         end
         ST_SWRST: begin
            if (cnt_q == 16'd0) begin
               state_d = ST_HOLD;
               cnt_d   = HoldLoad;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         default: state_d = ST_ASSERT;
      endcase

      rst_no_d = (state_d == ST_RUN);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= ST_ASSERT;
         sync_q   <= '0;
         cnt_q    <= '0;
         sw_q     <= 1'b0;
         rst_no_q <= 1'b0;
         ack_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         sw_q     <= sw_d;
         rst_no_q <= rst_no_d;
         ack_q    <= ack_d;
      end
   end

   assign bus.rst_no = rst_no_q;
   assign bus.busy_o = (state_q != ST_RUN);
   assign bus.ack_o  = ack_q;

`ifdef RST_SEQ_CTRL_STATS_EN
   logic [7:0] sw_cnt_q, sw_cnt_d;

   always_comb begin
      sw_cnt_d = sw_cnt_q;
      if (ack_d && (sw_cnt_q != 8'hFF)) begin
         sw_cnt_d = sw_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sw_cnt_q <= '0;
      end else begin
         sw_cnt_q <= sw_cnt_d;
      end
   end

   assign bus.sw_rst_cnt_o = sw_cnt_q;
`else
   assign bus.sw_rst_cnt_o = '0;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: two instances (S=2/H=100 and S=3/H=1) checked against
// durations computed from the sequencing rules.
module tb_rst_seq_ctrl;

   localparam int S_A = 2;
   localparam int H_A = 100;
   localparam int S_B = 3;
   localparam int H_B = 1;
`ifdef RST_SEQ_CTRL_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic        req      [2];
   logic [15:0] len      [2];
   logic        rst_no_s [2];
   logic        busy_s   [2];
   logic        ack_s    [2];
   logic [7:0]  cnt_s    [2];

   int n_chk = 0;
   int n_bad = 0;
   int done_sw [2];

   rst_seq_ctrl_if bus_a ();
   rst_seq_ctrl_if bus_b ();

   assign bus_a.req_i     = req[0];
   assign bus_a.req_len_i = len[0];
   assign bus_b.req_i     = req[1];
   assign bus_b.req_len_i = len[1];
   assign rst_no_s[0] = bus_a.rst_no;
   assign busy_s[0]   = bus_a.busy_o;
   assign ack_s[0]    = bus_a.ack_o;
   assign cnt_s[0]    = bus_a.sw_rst_cnt_o;
   assign rst_no_s[1] = bus_b.rst_no;
   assign busy_s[1]   = bus_b.busy_o;
   assign ack_s[1]    = bus_b.ack_o;
   assign cnt_s[1]    = bus_b.sw_rst_cnt_o;

   rst_seq_ctrl #(.SyncStages(S_A), .HoldCycles(H_A)) u_dut_a (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus_a)
   );

   rst_seq_ctrl #(.SyncStages(S_B), .HoldCycles(H_B)) u_dut_b (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus_b)
   );

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_chk++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int hold_of(input int d);
      return (d == 0) ? H_A : H_B;
   endfunction

   function automatic int exp_cnt(input int d);
      if (!STATS) return 0;
      return (done_sw[d] > 255) ? 255 : done_sw[d];
   endfunction

   // Counts edges after a release until each instance lets its reset go.
   task automatic power_on_measure();
      int rise [2];
      int acks;
      int busy_err;
      rise[0] = 0; rise[1] = 0; acks = 0; busy_err = 0;
      for (int k = 1; k <= 300; k++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 2; d++) begin
            if (ack_s[d]) acks++;
            if (rise[d] == 0 && !rst_no_s[d] && !busy_s[d]) busy_err++;
            if (rise[d] == 0 && rst_no_s[d]) begin
               rise[d] = k;
               check_val("busy_at_release", busy_s[d], 0);
            end
         end
         if (rise[0] != 0 && rise[1] != 0) break;
      end
      check_val("release_edge_a", rise[0], S_A + H_A);
      check_val("release_edge_b", rise[1], S_B + H_B);
      check_val("busy_before_release", busy_err, 0);
      check_val("poweron_no_ack", acks, 0);
   endtask

   task automatic pulse_reset();
      @(negedge clk); #1;
      rst_n = 1'b0;
      done_sw[0] = 0; done_sw[1] = 0;
      #2 rst_n = 1'b1;
   endtask

   // One software reset; early=1 raises the request while the sequencer is still busy.
   task automatic sw_reset(input int d, input int l, input bit early);
      int eff, lim, hi, lo, acks;
      eff = (l == 0) ? 1 : l;
      lim = eff + hold_of(d) + 20;
      hi = 0; lo = 0; acks = 0;
      @(negedge clk);
      if (!early) begin
         for (int i = 0; i < 400 && busy_s[d]; i++) @(negedge clk);
      end
      req[d] = 1'b1;
      len[d] = 16'(l);
      if (early) begin
         for (int i = 0; i < 400 && !rst_no_s[d]; i++) @(negedge clk);
      end else begin
         @(negedge clk);
      end
      while (rst_no_s[d] && hi < lim) begin
         hi++;
         @(negedge clk);
      end
      while (!rst_no_s[d] && lo < lim) begin
         if (ack_s[d]) acks++;
         lo++;
         @(negedge clk);
      end
      check_val("sw_high_before_fall", hi, early ? 1 : 0);
      check_val("sw_low_len", lo, eff + hold_of(d));
      check_val("sw_ack_early", acks, 0);
      check_val("sw_ack_at_rise", ack_s[d], 1);
      done_sw[d]++;
      check_val("sw_cnt", cnt_s[d], exp_cnt(d));
      req[d] = 1'b0;
      @(negedge clk);
      check_val("sw_ack_one_cycle", ack_s[d], 0);
      check_val("sw_run_after", rst_no_s[d], 1);
   endtask

   initial begin
      int acks;
      req[0] = 1'b0; req[1] = 1'b0;
      len[0] = '0;   len[1] = '0;
      done_sw[0] = 0; done_sw[1] = 0;

      #1 rst_n = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check_val("rst_rst_no", rst_no_s[d], 0);
         check_val("rst_busy", busy_s[d], 1);
         check_val("rst_ack", ack_s[d], 0);
         check_val("rst_cnt", cnt_s[d], 0);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      power_on_measure();

      sw_reset(0, 20, 1'b0);
      sw_reset(0, 0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         repeat ($urandom_range(0, 4)) @(negedge clk);
         sw_reset(0, int'($urandom_range(0, 50)), 1'b0);
      end
      for (int i = 0; i < 20; i++) begin
         repeat ($urandom_range(0, 4)) @(negedge clk);
         sw_reset(1, int'($urandom_range(0, 30)), 1'b0);
      end

      // Abort a software reset 10 clocks in with a sub-cycle raw reset pulse
      @(negedge clk);
      req[0] = 1'b1;
      len[0] = 16'd50;
      repeat (11) @(negedge clk);
      check_val("abort_pre_low", rst_no_s[0], 0);
      #1 rst_n = 1'b0;
      done_sw[0] = 0; done_sw[1] = 0;
      #1;
      check_val("abort_rst_no_a", rst_no_s[0], 0);
      check_val("abort_rst_no_b", rst_no_s[1], 0);
      check_val("abort_busy", busy_s[0], 1);
      check_val("abort_ack", ack_s[0], 0);
      check_val("abort_cnt", cnt_s[0], 0);
      req[0] = 1'b0;
      #1 rst_n = 1'b1;
      power_on_measure();
      check_val("abort_cnt_after", cnt_s[0], 0);

      pulse_reset();
      repeat (4) @(negedge clk);
      sw_reset(0, 7, 1'b1);

      // Back-to-back requests on the short-hold instance
      @(negedge clk);
      req[1] = 1'b1;
      len[1] = 16'd1;
      acks = 0;
      for (int i = 0; i < 2000 && acks < 260; i++) begin
         @(negedge clk);
         if (ack_s[1]) begin
            acks++;
            done_sw[1]++;
            if (acks == 1 || acks == 255 || acks == 256 || acks == 260)
               check_val("sat_cnt", cnt_s[1], exp_cnt(1));
         end
      end
      req[1] = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (ack_s[1]) acks++;
      end
      check_val("sat_acks", acks, 260);
      check_val("sat_cnt_final", cnt_s[1], exp_cnt(1));

      for (int i = 0; i < 5; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         sw_reset(1, int'($urandom_range(0, 10)), 1'b0);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
